// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: FSM encoding and player position/angle widths shared with draw_fpv and movement logic
package frame_sequencer_pkg;
  localparam int POS_X_W = 14;
  localparam int POS_Y_W = 13;
  localparam int ANGLE_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    FRAME_END = 3'd4
  } state_t;
endpackage

// File: rtl/frame_sequencer_tick.sv
// frame_tick_divider: free-running frame period counter with a one-cycle tick on its last count
module frame_tick_divider #(
  parameter int FRAME_TICKS = 833333,
  parameter int TICK_W = 20
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);
  localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAME_TICKS - 1);
  logic [TICK_W-1:0] count;
  assign tick = count == LAST;
  // wrap 0..FRAME_TICKS-1 regardless of sequencer state
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) count <= '0;
    else count <= tick ? '0 : count + TICK_W'(1);
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: paces draw_fpv frames, snapshots player pose, reports completion/overrun (FRAME_SEQ_OVERRUN_CNT_EN adds overrun_count)
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int TICK_W = 20
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic [POS_X_W-1:0] live_pos_x,
  input  logic [POS_Y_W-1:0] live_pos_y,
  input  logic [ANGLE_W-1:0] live_angle,
  output logic [POS_X_W-1:0] player_pos_x,
  output logic [POS_Y_W-1:0] player_pos_y,
  output logic [ANGLE_W-1:0] player_angle,
  output logic               fpv_start,
  input  logic               fpv_done,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_count,
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  output logic [7:0]         overrun_count,
`endif
  output logic               overrun
);
  state_t state;
  logic tick, tick_pending, overrun_evt;
  frame_tick_divider #(.FRAME_TICKS(FRAME_TICKS), .TICK_W(TICK_W)) u_div (
    .clock (clock),
    .resetn(resetn),
    .tick  (tick)
  );
  assign overrun_evt = tick && tick_pending && state != LATCH;
  // a tick arms the next frame; LATCH consumes it unless a new tick lands in the same cycle
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) tick_pending <= 1'b1;
    else tick_pending <= tick || (tick_pending && state != LATCH);
  // frame FSM with registered strobes, busy flag, snapshot and frame counter
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state        <= IDLE;
      player_pos_x <= '0;
      player_pos_y <= '0;
      player_angle <= '0;
      fpv_start    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      fpv_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable && tick_pending) begin
          state <= LATCH;
          busy  <= 1'b1;
        end
        LATCH: begin
          player_pos_x <= live_pos_x;
          player_pos_y <= live_pos_y;
          player_angle <= live_angle;
          fpv_start    <= 1'b1;
          state        <= START;
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: if (fpv_done) begin
          state       <= FRAME_END;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  // sticky overrun flag plus saturating count of overrun events
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else if (overrun_evt) begin
      overrun       <= 1'b1;
      overrun_count <= overrun_count + {7'd0, overrun_count != 8'hFF};
    end
`else
  // sticky overrun flag
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) overrun <= 1'b0;
    else if (overrun_evt) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench for frame_sequencer with a stubbed draw_fpv
module tb_frame_sequencer;
  localparam int FT = 100;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic enable, fpv_done;
  logic [13:0] live_pos_x, player_pos_x;
  logic [12:0] live_pos_y, player_pos_y;
  logic [7:0] live_angle, player_angle, frame_count;
  logic fpv_start, busy, frame_done, overrun;
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif
  logic [13:0] exp_x;
  logic [12:0] exp_y;
  logic [7:0] exp_a, exp_cnt;
  logic [7:0] sb[$];
  int n_chk = 0, n_pass = 0, gen = 0, done_delay = 10, fdone_cnt = 0;

  frame_sequencer #(.FRAME_TICKS(FT), .TICK_W(20)) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .live_pos_x(live_pos_x), .live_pos_y(live_pos_y), .live_angle(live_angle),
    .player_pos_x(player_pos_x), .player_pos_y(player_pos_y), .player_angle(player_angle),
    .fpv_start(fpv_start), .fpv_done(fpv_done), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count),
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!fpv_start && n < lim);
  endtask

  task automatic wait_fdone(input int lim, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!frame_done && n < lim);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clock);
    #1 resetn = 1'b0;
    gen++;
    fpv_done = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    if (check) begin
      chk("async_busy", busy, 0);
      chk("async_start", fpv_start, 0);
      chk("async_frame_done", frame_done, 0);
      chk("async_count", frame_count, 0);
      chk("async_overrun", overrun, 0);
      chk("async_x", player_pos_x, 0);
      chk("async_y", player_pos_y, 0);
      chk("async_a", player_angle, 0);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // draw_fpv stub: answers each start after done_delay cycles and pushes the expected frame count
  initial forever begin
    @(negedge clock);
    if (resetn && fpv_start)
      fork
        begin
          automatic int g = gen;
          automatic int d = done_delay;
          repeat (d - 1) @(negedge clock);
          #2;
          if (g == gen) begin
            fpv_done = 1'b1;
            exp_cnt = exp_cnt + 8'd1;
            sb.push_back(exp_cnt);
            @(negedge clock);
            #2 fpv_done = 1'b0;
          end
        end
      join_none
  end

  // output monitor: snapshot at every start, frame_done one cycle after fpv_done, scoreboard count
  initial forever begin
    @(negedge clock);
    if (resetn) begin
      if (fpv_start) begin
        chk("snap_x", player_pos_x, exp_x);
        chk("snap_y", player_pos_y, exp_y);
        chk("snap_a", player_angle, exp_a);
        chk("busy_at_start", busy, 1);
      end
      if (frame_done || fpv_done) chk("done_to_frame_done", frame_done, fpv_done);
      if (frame_done) begin
        fdone_cnt++;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) chk("frame_count", frame_count, sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    enable = 1'b1;
    fpv_done = 1'b0;
    {live_pos_x, live_pos_y, live_angle} = {14'd1000, 13'd500, 8'd64};
    {exp_x, exp_y, exp_a} = {14'd1000, 13'd500, 8'd64};
    exp_cnt = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_x", player_pos_x, 0);
    chk("rst_start", fpv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clock);
    resetn = 1'b1;
    wait_start(10, n);
    chk("first_start_lat", n, 2);
    wait_start(3 * FT, n);
    chk("frame_period", n, FT);
    repeat (3) @(negedge clock);
    {live_pos_x, live_pos_y, live_angle} = {14'd2000, 13'd900, 8'd200};
    chk("hold_x", player_pos_x, 1000);
    chk("hold_y", player_pos_y, 500);
    chk("hold_a", player_angle, 64);
    wait_fdone(50, n);
    chk("hold_x_end", player_pos_x, 1000);
    {exp_x, exp_y, exp_a} = {14'd2000, 13'd900, 8'd200};
    wait_start(3 * FT, n);
    chk("new_snap_x", player_pos_x, 2000);
    #1 done_delay = 250;
    wait_start(3 * FT, n);
    chk("frame_period2", n, FT);
    chk("no_overrun_yet", overrun, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!overrun && n < 4 * FT);
    chk("overrun_at_second_tick", n, 2 * FT - 2);
    wait_fdone(2 * FT, n);
    done_delay = 10;
    wait_start(10, n);
    chk("catchup_start_lat", n, 3);
    chk("overrun_sticky", overrun, 1);
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    chk("overrun_count1", overrun_count, 1);
`endif
    wait_start(3 * FT, n);
    repeat (3) @(negedge clock);
    do_reset(1);
    n = 0;
    for (int i = 1; i <= 3 * FT; i++) begin
      @(negedge clock);
      if (i == 1) chk("post_rst_count", frame_count, 0);
      if (i == 2) chk("post_rst_start", fpv_start, 1);
      if (i == 5) enable = 1'b0;
      if (i >= 3 && fpv_start) n++;
      if (i == 2 * FT - 1) chk("gate_overrun_pre", overrun, 0);
      if (i == 2 * FT) chk("gate_overrun_post", overrun, 1);
    end
    chk("gated_starts", n, 0);
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    chk("overrun_count2", overrun_count, 2);
`endif
    enable = 1'b1;
    wait_start(10, n);
    chk("reenable_start_lat", n, 2);
    do_reset(0);
    fdone_cnt = 0;
    for (int c = 0; c < 270 * FT && fdone_cnt < 256; c++) @(negedge clock);
    chk("wrap_pulses", fdone_cnt, 256);
    chk("wrap_count", frame_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
